fir_seq_buf: RTL

FIR_SEQ_BUF -- requirements
Module: fir_seq_buf

---
 rtl/fir_seq_buf.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fir_seq_buf.sv
// Circular sample buffer that replays the newest NUM_TAPS samples, oldest first,
// to a FIR core after every accepted write once the buffer has filled.
module fir_seq_buf #(
    parameter int NUM_TAPS = 1021,
    parameter int DEPTH    = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wrt_smpl,
    input  logic signed [15:0] smpl_in,
    input  logic               clr_ovr,
    output logic               sequencing,
    output logic signed [15:0] smpl_out,
    output logic               full,
    output logic               ovr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(NUM_TAPS + 1);
    localparam logic [AW-1:0] TAPS_A = AW'(NUM_TAPS);
    localparam logic [CW-1:0] TAPS_C = CW'(NUM_TAPS);
    localparam logic [CW-1:0] LAST_K = CW'(NUM_TAPS - 1);

    typedef enum logic [1:0] {IDLE, LEAD, STREAM} state_t;

    state_t             state;
    logic signed [15:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [CW-1:0]      k_cnt;
    logic               pend_vld;
    logic signed [15:0] pend_data;

    logic               busy;
    logic               mem_we;
    logic signed [15:0] mem_wdata;
    logic [CW-1:0]      count_nxt;
    logic               drop;

    // NOTE: every always_comb output is assigned unconditionally, so no latch can be inferred.
    always_comb begin
        busy      = (state != IDLE);
        mem_we    = !busy && (pend_vld || wrt_smpl);
        mem_wdata = pend_vld ? pend_data : smpl_in;
        count_nxt = (count == TAPS_C) ? count : count + CW'(1);
        drop      = busy && wrt_smpl && pend_vld;
    end

    assign full = (count == TAPS_C);

    // NOTE: the sample memory has no reset; only pointers and counters define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) mem[wr_ptr] <= mem_wdata;
    end

    // Writes only happen in IDLE, so the window being streamed is never disturbed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            k_cnt      <= '0;
            pend_vld   <= 1'b0;
            pend_data  <= '0;
            sequencing <= 1'b0;
            smpl_out   <= '0;
            ovr        <= 1'b0;
        end else begin
            ovr <= drop || (ovr && !clr_ovr);

            if (busy && wrt_smpl && !pend_vld) begin
                pend_vld  <= 1'b1;
                pend_data <= smpl_in;
            end

            case (state)
                IDLE: begin
                    sequencing <= 1'b0;
                    smpl_out   <= '0;
                    if (mem_we) begin
                        wr_ptr   <= wr_ptr + AW'(1);
                        count    <= count_nxt;
                        pend_vld <= pend_vld && wrt_smpl;
                        if (pend_vld && wrt_smpl) pend_data <= smpl_in;
                        if (count_nxt == TAPS_C) begin
                            state      <= LEAD;
                            sequencing <= 1'b1;
                            rd_ptr     <= wr_ptr + AW'(1) - TAPS_A;
                        end
                    end
                end
                LEAD: begin
                    smpl_out <= mem[rd_ptr];
                    rd_ptr   <= rd_ptr + AW'(1);
                    k_cnt    <= '0;
                    state    <= STREAM;
                end
                STREAM: begin
                    if (k_cnt == LAST_K) begin
                        state      <= IDLE;
                        sequencing <= 1'b0;
                        smpl_out   <= '0;
                    end else begin
                        smpl_out <= mem[rd_ptr];
                        rd_ptr   <= rd_ptr + AW'(1);
                        k_cnt    <= k_cnt + CW'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    sequencing <= 1'b0;
                    smpl_out   <= '0;
                end
            endcase
        end
    end

endmodule
